// File: rtl/pll_phase_sequencer.sv
// pll_phase_sequencer: arbitrates phase-step, clkswitch and areset access to the PLL reconfiguration pins,
// stepping with a synchronized phasedone handshake and a per-step timeout.
module pll_phase_sequencer #(
    parameter int SCAN_DIV     = 16,
    parameter int PULSE_TICKS  = 8,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_req,
    input  logic [2:0] host_sel,
    input  logic       host_updown,
    input  logic [7:0] host_count,
    input  logic       scan_req,
    input  logic [2:0] scan_sel,
    input  logic       scan_updown,
    input  logic [7:0] scan_count,
    input  logic       areset_req,
    input  logic       clkswitch_req,
    input  logic       phasedone,
    output logic       host_done,
    output logic       scan_done,
    output logic       err_timeout,
    output logic       busy,
    output logic [7:0] steps_done,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       scanclk,
    output logic       areset,
    output logic       clkswitch
);
    localparam int PW = $clog2(PULSE_TICKS + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARESET, CLKSW, STEP, WAITLO, WAITHI, GAP} state_t;

    state_t        state;
    logic          pd_m, pd_s, second, job_scan;
    logic [7:0]    div, count, cnt_g, steps_inc;
    logic [PW-1:0] tick;
    logic [TW-1:0] timer;
    logic [2:0]    sel_g;
    logic          ud_g, sc_tog, sc_rise, step_ok, timed_out, pulse_end;

    assign sel_g     = host_req ? host_sel : scan_sel;
    assign ud_g      = host_req ? host_updown : scan_updown;
    assign cnt_g     = host_req ? host_count : scan_count;
    assign sc_tog    = div == 8'(SCAN_DIV - 1);
    assign sc_rise   = sc_tog && !scanclk;
    assign steps_inc = steps_done + 8'd1;
    assign step_ok   = state == WAITHI && pd_s;
    assign pulse_end = tick == PW'(PULSE_TICKS - 1);
    assign timed_out = (state == STEP || state == WAITLO || state == WAITHI) &&
                       timer == TW'(DONE_TIMEOUT - 1) && !step_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            pd_m               <= 1'b0;
            pd_s               <= 1'b0;
            second             <= 1'b0;
            job_scan           <= 1'b0;
            div                <= '0;
            count              <= '0;
            tick               <= '0;
            timer              <= '0;
            host_done          <= 1'b0;
            scan_done          <= 1'b0;
            err_timeout        <= 1'b0;
            busy               <= 1'b0;
            steps_done         <= '0;
            phasecounterselect <= '0;
            phaseupdown        <= 1'b1;
            phasestep          <= 1'b0;
            scanclk            <= 1'b0;
            areset             <= 1'b0;
            clkswitch          <= 1'b0;
        end else begin
            host_done   <= 1'b0;
            scan_done   <= 1'b0;
            err_timeout <= 1'b0;
            pd_m        <= phasedone;
            pd_s        <= pd_m;
            timer       <= timer + 1'b1;
            tick        <= tick + 1'b1;
            if (state inside {STEP, WAITLO, WAITHI, GAP}) begin
                div <= sc_tog ? 8'd0 : div + 8'd1;
                if (sc_tog) scanclk <= ~scanclk;
            end
            case (state)
                IDLE: begin
                    tick <= '0;
                    if (areset_req) begin
                        state  <= ARESET;
                        areset <= 1'b1;
                        busy   <= 1'b1;
                    end else if (clkswitch_req) begin
                        state     <= CLKSW;
                        clkswitch <= 1'b1;
                        busy      <= 1'b1;
                    end else if (host_req || scan_req) begin
                        job_scan   <= !host_req;
                        count      <= cnt_g;
                        steps_done <= '0;
                        if (cnt_g == 8'd0) begin
                            host_done <= host_req;
                            scan_done <= !host_req;
                        end else begin
                            state              <= STEP;
                            busy               <= 1'b1;
                            phasestep          <= 1'b1;
                            scanclk            <= 1'b0;
                            div                <= '0;
                            second             <= 1'b0;
                            timer              <= '0;
                            phasecounterselect <= sel_g;
                            phaseupdown        <= ud_g;
                        end
                    end
                end
                ARESET, CLKSW: if (pulse_end) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    areset    <= 1'b0;
                    clkswitch <= 1'b0;
                end
                STEP: if (sc_rise) begin
                    second <= 1'b1;
                    if (second) begin
                        phasestep <= 1'b0;
                        state     <= WAITLO;
                    end
                end
                WAITLO: if (!pd_s) state <= WAITHI;
                WAITHI: if (pd_s) begin
                    steps_done <= steps_inc;
                    if (steps_inc == count) begin
                        host_done <= !job_scan;
                        scan_done <= job_scan;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        scanclk   <= 1'b0;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: if (sc_rise) begin
                    state     <= STEP;
                    phasestep <= 1'b1;
                    second    <= 1'b0;
                    timer     <= '0;
                end
                default: state <= IDLE;
            endcase
            // The handshake deadline overrides whatever the current state decided this cycle
            if (timed_out) begin
                err_timeout <= 1'b1;
                phasestep   <= 1'b0;
                scanclk     <= 1'b0;
                busy        <= 1'b0;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pll_phase_sequencer.sv
// tb_pll_phase_sequencer: directed and randomized jobs against a PLL phasedone model and a job-level
// reference of expected steps, done pulses and pulse widths.
module tb_pll_phase_sequencer;
    localparam int SD = 4, PT = 8, DT = 1024;

    logic clk = 0, reset = 1;
    logic host_req = 0, scan_req = 0, areset_req = 0, clkswitch_req = 0, phasedone = 1;
    logic [2:0] host_sel = 0, scan_sel = 0;
    logic host_updown = 0, scan_updown = 0;
    logic [7:0] host_count = 0, scan_count = 0;
    logic host_done, scan_done, err_timeout, busy, phasestep, scanclk, areset, clkswitch, phaseupdown;
    logic [7:0] steps_done;
    logic [2:0] phasecounterselect;

    pll_phase_sequencer #(.SCAN_DIV(SD), .PULSE_TICKS(PT), .DONE_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_sel(host_sel), .host_updown(host_updown), .host_count(host_count),
        .scan_req(scan_req), .scan_sel(scan_sel), .scan_updown(scan_updown), .scan_count(scan_count),
        .areset_req(areset_req), .clkswitch_req(clkswitch_req), .phasedone(phasedone),
        .host_done(host_done), .scan_done(scan_done), .err_timeout(err_timeout), .busy(busy),
        .steps_done(steps_done), .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
        .phasestep(phasestep), .scanclk(scanclk), .areset(areset), .clkswitch(clkswitch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PLL model: phasedone drops d1 scanclk edges after phasestep falls, rises d2 edges later
    int mode = 0, d1 = 3, d2 = 4, pcnt = 0;
    bit pact = 0;
    logic pps = 0, psc = 0;
    always @(negedge clk) begin
        if (reset) begin
            phasedone = 1;
            pact = 0;
        end else if (pps && !phasestep && mode == 0) begin
            pact = 1;
            pcnt = 0;
        end else if (pact && scanclk != psc) begin
            pcnt++;
            if (pcnt == d1) phasedone = 0;
            if (pcnt == d1 + d2) begin
                phasedone = 1;
                pact = 0;
            end
        end
        pps = phasestep;
        psc = scanclk;
    end

    typedef struct {logic [2:0] sel; logic ud; int rises; bit stable;} step_t;
    step_t sq[$];
    int n_hd = 0, n_sd = 0, n_err = 0, n_ar = 0, n_cs = 0, n_busy = 0, n_tog = 0;
    int cur_rises = 0, ps_rise_cyc = 0, err_cyc = 0, hd_cyc = 0, sd_cyc = 0, busy_rise_cyc = 0;
    logic [2:0] ps_sel = 0;
    logic ps_ud = 0, mps = 0, msc = 0, mbusy = 0;
    always @(negedge clk) begin
        if (mps && !msc && scanclk) cur_rises++;
        if (!mps && phasestep) begin
            cur_rises = 0;
            ps_sel = phasecounterselect;
            ps_ud = phaseupdown;
            ps_rise_cyc = cyc;
        end
        if (mps && !phasestep)
            sq.push_back('{ps_sel, ps_ud, cur_rises, phasecounterselect == ps_sel && phaseupdown == ps_ud});
        if (host_done) begin n_hd++; hd_cyc = cyc; end
        if (scan_done) begin n_sd++; sd_cyc = cyc; end
        if (err_timeout) begin n_err++; err_cyc = cyc; end
        if (areset) n_ar++;
        if (clkswitch) n_cs++;
        if (busy) n_busy++;
        if (busy && !mbusy) busy_rise_cyc = cyc;
        if (scanclk != msc) n_tog++;
        mps = phasestep;
        msc = scanclk;
        mbusy = busy;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_job(input bit scan, input int cnt, input int sel, input bit ud,
                           output int h0, output int s0, output int e0, output int q0,
                           output int req_cyc, output bit first_busy);
        h0 = n_hd; s0 = n_sd; e0 = n_err; q0 = sq.size();
        if (scan) begin
            scan_count = 8'(cnt); scan_sel = 3'(sel); scan_updown = ud; scan_req = 1;
        end else begin
            host_count = 8'(cnt); host_sel = 3'(sel); host_updown = ud; host_req = 1;
        end
        req_cyc = cyc;
        tick();
        first_busy = busy;
        for (int i = 0; i < 20000 && n_hd == h0 && n_sd == s0 && n_err == e0; i++) tick();
        host_req = 0;
        scan_req = 0;
        chk("job_finished", (n_hd != h0 || n_sd != s0 || n_err != e0), 1);
    endtask

    task automatic check_job(input string tag, input bit scan, input int cnt, input int sel, input bit ud,
                             input int h0, input int s0, input int e0, input int q0, input bit first_busy);
        int good = 0;
        for (int i = q0; i < sq.size(); i++)
            good += int'(sq[i].sel == 3'(sel) && sq[i].ud == ud && sq[i].rises == 2 && sq[i].stable);
        chk({tag, "_host_done"}, n_hd - h0, scan ? 0 : 1);
        chk({tag, "_scan_done"}, n_sd - s0, scan ? 1 : 0);
        chk({tag, "_no_err"}, n_err - e0, 0);
        chk({tag, "_steps_done"}, steps_done, cnt);
        chk({tag, "_step_count"}, sq.size() - q0, cnt);
        chk({tag, "_good_steps"}, good, cnt);
        chk({tag, "_busy_after_grant"}, first_busy, cnt != 0);
    endtask

    initial begin
        int h0, s0, e0, q0, rc, b0, t0, good;
        bit fb;
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_steps", steps_done, 0);
        chk("rst_pins", {phasestep, scanclk, areset, clkswitch}, 0);
        chk("rst_sel", phasecounterselect, 0);
        chk("rst_updown", phaseupdown, 1);
        chk("rst_pulses", {host_done, scan_done, err_timeout}, 0);
        reset = 0;
        tick();

        // areset pulse
        h0 = n_hd; s0 = n_sd; b0 = n_busy; t0 = n_tog; q0 = n_ar;
        areset_req = 1; tick(); areset_req = 0;
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("areset_width", n_ar - q0, PT);
        chk("areset_busy", n_busy - b0, PT);
        chk("areset_no_done", (n_hd - h0) + (n_sd - s0), 0);
        chk("areset_no_scanclk", n_tog - t0, 0);

        // clkswitch pulse
        b0 = n_busy; q0 = n_cs;
        clkswitch_req = 1; tick(); clkswitch_req = 0;
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("clksw_width", n_cs - q0, PT);
        chk("clksw_busy", n_busy - b0, PT);

        // directed host job: 3 steps, sel 011, down
        run_job(0, 3, 3, 0, h0, s0, e0, q0, rc, fb);
        check_job("host3", 0, 3, 3, 0, h0, s0, e0, q0, fb);

        // simultaneous host/scan requests with mid-job field changes
        h0 = n_hd; s0 = n_sd; e0 = n_err; q0 = sq.size();
        host_count = 1; host_sel = 1; host_updown = 1;
        scan_count = 2; scan_sel = 5; scan_updown = 0;
        host_req = 1; scan_req = 1;
        for (int i = 0; i < 20000 && n_sd == s0; i++) begin
            tick();
            if (i == 10) begin host_sel = 6; host_updown = 0; host_count = 9; end
            if (n_hd != h0) host_req = 0;
            if (n_hd != h0 && busy) begin scan_sel = 2; scan_updown = 1; scan_count = 7; end
        end
        scan_req = 0; host_req = 0;
        good = 0;
        for (int i = q0; i < sq.size(); i++)
            good += int'(sq[i].sel == (i == q0 ? 3'd1 : 3'd5) && sq[i].ud == (i == q0) && sq[i].rises == 2);
        chk("arb_host_done", n_hd - h0, 1);
        chk("arb_scan_done", n_sd - s0, 1);
        chk("arb_order", sd_cyc > hd_cyc, 1);
        chk("arb_gap", busy_rise_cyc - hd_cyc, 1);
        chk("arb_steps_total", sq.size() - q0, 3);
        chk("arb_good_steps", good, 3);
        chk("arb_steps_done", steps_done, 2);
        tick();

        // timeout: phasedone never drops
        mode = 1;
        run_job(0, 2, 4, 1, h0, s0, e0, q0, rc, fb);
        chk("to_err", n_err - e0, 1);
        chk("to_no_done", (n_hd - h0) + (n_sd - s0), 0);
        chk("to_latency", err_cyc - ps_rise_cyc, DT);
        chk("to_idle", {busy, phasestep, scanclk}, 0);
        chk("to_steps", steps_done, 0);
        mode = 0;
        tick();

        // zero count
        t0 = n_tog;
        run_job(1, 0, 2, 1, h0, s0, e0, q0, rc, fb);
        chk("zero_latency", sd_cyc - rc, 1);
        chk("zero_no_scanclk", n_tog - t0, 0);
        check_job("zero", 1, 0, 2, 1, h0, s0, e0, q0, fb);
        tick(); tick();

        // reset while waiting for phasedone low
        q0 = sq.size();
        host_count = 2; host_sel = 7; host_updown = 0; host_req = 1;
        for (int i = 0; i < 2000 && sq.size() == q0; i++) tick();
        chk("mid_reached_waitlo", sq.size() - q0, 1);
        reset = 1; host_req = 0;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_pins", {phasestep, scanclk, areset, clkswitch}, 0);
        chk("mid_fields", {phasecounterselect, phaseupdown, steps_done}, {3'd0, 1'b1, 8'd0});
        reset = 0;
        tick(); tick();
        run_job(0, 2, 2, 1, h0, s0, e0, q0, rc, fb);
        check_job("post_reset", 0, 2, 2, 1, h0, s0, e0, q0, fb);

        // randomized jobs
        for (int n = 0; n < 8; n++) begin
            bit sc, ud;
            int cnt, sel;
            sc = 1'($urandom);
            ud = 1'($urandom);
            cnt = $urandom_range(0, 4);
            sel = $urandom_range(0, 7);
            d1 = $urandom_range(1, 4);
            d2 = $urandom_range(1, 4);
            tick();
            run_job(sc, cnt, sel, ud, h0, s0, e0, q0, rc, fb);
            check_job($sformatf("rand%0d", n), sc, cnt, sel, ud, h0, s0, e0, q0, fb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_phase_sequencer.md
# pll_phase_sequencer

Arbitrates and sequences all access to the PLL reconfiguration pins: dynamic phase stepping, clock-input switch and PLL reset. Two phase-step requesters share the PLL: the host command path and an automatic phase-scan engine. Standalone reset and clkswitch requests are also served. The block sits between the serial command processor / scan logic and the PLL instance. It replaces open-loop scanclk toggling with a phasedone-checked handshake.

## Interface
Parameters:
- SCAN_DIV, 16: clk cycles per scanclk half-period (2..255).
- PULSE_TICKS, 8: clk cycles areset or clkswitch is held high.
- DONE_TIMEOUT, 1024: clk cycles allowed per step for the phasedone handshake.

Ports:
- clk, in, 1: the single clock.
- reset, in, 1: **synchronous, active-high** reset.
- host_req, in, 1: level; host phase-step job request.
- host_sel, in, 3: counter select (000 all, 011 C1, …).
- host_updown, in, 1: direction; 1 = up.
- host_count, in, 8: number of steps.
- scan_req / scan_sel / scan_updown / scan_count: same meaning for the scan requester.
- areset_req, in, 1: request a PLL reset pulse.
- clkswitch_req, in, 1: request a clkswitch pulse.
- phasedone, in, 1: asynchronous, from the PLL.
- host_done, out, 1: one-cycle pulse when the host job ends.
- scan_done, out, 1: one-cycle pulse when the scan job ends.
- err_timeout, out, 1: one-cycle pulse when a job is aborted.
- busy, out, 1: high in every state except IDLE.
- steps_done, out, 8: steps completed in the current or last job.
- phasecounterselect, out, 3: to PLL.
- phaseupdown, out, 1: to PLL.
- phasestep, out, 1: to PLL.
- scanclk, out, 1: to PLL.
- areset, out, 1: to PLL.
- clkswitch, out, 1: to PLL.

## Operation
- phasedone passes through a 2-flop synchronizer before any use (pd_s).
- States: IDLE, ARESET, CLKSW, STEP, WAITLO, WAITHI, GAP.
- **IDLE arbitration** is fixed priority, evaluated once per cycle: areset_req > clkswitch_req > host_req > scan_req.
  - Job fields are latched at grant; later changes of sel, updown or count are ignored until the next grant.
  - steps_done clears at grant.
- **ARESET / CLKSW**
  - The output is high for exactly PULSE_TICKS cycles, then the FSM returns to IDLE.
  - No done pulse is produced.
  - areset also forces phasestep = 0 and scanclk = 0.
- **Job with count = 0**: the done pulse for that requester fires the cycle after grant; no PLL activity; FSM returns to IDLE.
- **Job with count > 0**
  - The latched sel and updown drive phasecounterselect and phaseupdown for the whole job.
  - scanclk runs (toggles every SCAN_DIV cycles, starting low) from entry into STEP until the return to IDLE.
- **STEP**: phasestep = 1 until two scanclk rising edges have occurred, deasserted on the cycle of the second rise; then go to WAITLO.
- **WAITLO**: wait for pd_s = 0; then go to WAITHI.
- **WAITHI**: wait for pd_s = 1; then steps_done += 1.
  - If steps_done now equals count: pulse done, go to IDLE.
  - Otherwise go to GAP.
- **GAP**: wait for one further scanclk rising edge, then re-enter STEP.
- **Timeout**
  - A counter restarts on each entry to STEP.
  - If WAITHI is not exited within DONE_TIMEOUT cycles: pulse err_timeout (not done), phasestep = 0, go to IDLE.
  - steps_done keeps its value.
- **Requests during a job** (areset_req, other requesters) are not serviced until IDLE; a job is never pre-empted.
- A requester holding req high after its done pulse is granted a new job; requesters must drop req on done.

## Timing
- **Reset values**:
  - All control outputs 0: busy, done/err pulses, steps_done, phasestep, scanclk, areset, clkswitch, phasecounterselect.
  - Exception: phaseupdown resets to 1.
  - FSM in IDLE; synchronizer flops 0.
- **reset mid-operation** returns to IDLE in one cycle with all outputs at reset values; the PLL pins drop immediately.
- **Grant latency**: req sampled high in IDLE → busy high the next cycle; phasestep and first-half scanclk low start that same cycle.
- **Per-step minimum**: about 5·SCAN_DIV cycles plus handshake latency.
  - pd_s observes phasedone 2 cycles after its edge.
- **Simultaneous requests**: the lower-priority requester is served in the IDLE cycle after the higher job returns.
- **steps_done** wraps never; it is bounded by count ≤ 255.

## Test plan
- **Reset pulse**: areset_req one cycle, PULSE_TICKS = 8 → areset high exactly 8 cycles, busy 8 cycles, no done pulses.
- **Single host step**: host_count = 3, sel = 011, updown = 0, model PLL drops phasedone 3 scanclk edges after the phasestep fall and raises it 4 edges later → 3 steps, phasestep high over exactly two scanclk rises each step, host_done once, steps_done = 3, phaseupdown = 0 throughout.
- **Arbitration**: host_req and scan_req rise the same cycle, counts 1 and 2 → host job first, scan granted the cycle after return to IDLE, scan_done after 2 steps; fields changed mid-job are ignored.
- **Timeout**: model never drops phasedone, DONE_TIMEOUT = 1024 → err_timeout pulse 1024 cycles after STEP entry, no done pulse, phasestep 0, back in IDLE.
- **Zero count**: scan_count = 0 → scan_done the cycle after grant, scanclk never toggles.
- **Reset mid-step**: reset in WAITLO → next cycle all outputs at reset values, busy 0, later job runs normally.
